// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - iterative RV32M-style multiply/divide unit, one bit per cycle
//
// Parameters
//   WIDTH  operand/result width in bits (even, 8..64)
//   TAG_W  width of the pass-through destination tag
//
// Ports
//   i_clk      single clock
//   i_rst_n    asynchronous active-low reset
//   i_valid    request valid            o_ready   unit idle, can accept a request
//   i_funct3   000 mul, 001 mulh, 010 mulhsu, 011 mulhu,
//              100 div, 101 divu, 110 rem, 111 remu
//   i_op_a     rs1 operand              i_op_b    rs2 operand
//   i_tag      destination tag, returned unchanged on o_tag
//   i_flush    abort any in-flight operation (wins over i_valid / i_ready)
//   o_valid    result valid             i_ready   consumer accepts result
//   o_result   result                   o_tag     tag latched with the request
//
// Configuration macro
//   MULDIV_EARLY_OUT_EN  when defined, divide-by-zero, signed overflow and
//                        multiply by zero finish one edge after acceptance.
//                        Results are identical either way.

module muldiv_unit #(
    parameter int WIDTH = 32,
    parameter int TAG_W = 5
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_valid,
    output logic               o_ready,
    input  logic [2:0]         i_funct3,
    input  logic [WIDTH-1:0]   i_op_a,
    input  logic [WIDTH-1:0]   i_op_b,
    input  logic [TAG_W-1:0]   i_tag,
    input  logic               i_flush,
    output logic               o_valid,
    input  logic               i_ready,
    output logic [WIDTH-1:0]   o_result,
    output logic [TAG_W-1:0]   o_tag
);

`ifdef MULDIV_EARLY_OUT_EN
    localparam logic EARLY_OUT = 1'b1;
`else
    localparam logic EARLY_OUT = 1'b0;
`endif

    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
    localparam logic [WIDTH-1:0] MIN_NEG  = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state, state_nxt;

    // Latched request context
    logic [2:0]        funct_q;
    logic [TAG_W-1:0]  tag_q;
    logic              neg_q;          // final result must be negated
    logic              special_q;      // result known at acceptance
    logic [WIDTH-1:0]  special_val_q;
    logic [CNT_W-1:0]  cnt;

    // Shared iteration registers:
    //   multiply: hi = partial product high half, lo = multiplier (shifts out)
    //   divide:   hi = partial remainder,        lo = dividend in / quotient out
    //   opb:      multiplicand magnitude or divisor magnitude
    logic [WIDTH-1:0]  hi, lo, opb;

    // ---------------------------------------------------------------
    // Request decode (on the incoming operands)
    // ---------------------------------------------------------------
    logic              req_mul, a_signed, b_signed, a_neg, b_neg, req_neg;
    logic [WIDTH-1:0]  a_mag, b_mag;
    logic              div_zero, div_ovf, mul_zero, req_special;
    logic [WIDTH-1:0]  req_special_val;
    logic              accept;

    always_comb begin
        req_mul  = ~i_funct3[2];
        // Plain mul only needs the low half, which is sign-agnostic.
        a_signed = req_mul ? (i_funct3[1:0] == 2'b01 || i_funct3[1:0] == 2'b10)
                           : ~i_funct3[0];
        b_signed = req_mul ? (i_funct3[1:0] == 2'b01) : ~i_funct3[0];
        a_neg    = a_signed & i_op_a[WIDTH-1];
        b_neg    = b_signed & i_op_b[WIDTH-1];
        // Negating MIN_NEG yields MIN_NEG, which is the correct unsigned magnitude.
        a_mag    = a_neg ? (~i_op_a + 1'b1) : i_op_a;
        b_mag    = b_neg ? (~i_op_b + 1'b1) : i_op_b;
        // Remainder takes the dividend's sign; quotient/product the xor.
        req_neg  = (req_mul || !i_funct3[1]) ? (a_neg ^ b_neg) : a_neg;

        div_zero = !req_mul && (i_op_b == '0);
        div_ovf  = !req_mul && !i_funct3[0] && (i_op_a == MIN_NEG) && (i_op_b == '1);
        mul_zero = req_mul && ((i_op_a == '0) || (i_op_b == '0));
        req_special = div_zero || div_ovf || mul_zero;

        req_special_val = '0;
        if (div_zero)
            req_special_val = i_funct3[1] ? i_op_a : '1;
        else if (div_ovf)
            req_special_val = i_funct3[1] ? '0 : MIN_NEG;

        accept = (state == IDLE) && i_valid && !i_flush;
    end

    // ---------------------------------------------------------------
    // One iteration step
    // ---------------------------------------------------------------
    logic [WIDTH:0]    mul_sum;
    logic [WIDTH-1:0]  mul_hi_n, mul_lo_n;
    logic [WIDTH:0]    div_shift, div_diff;
    logic [WIDTH-1:0]  div_hi_n, div_lo_n;

    always_comb begin
        mul_sum  = {1'b0, hi} + (lo[0] ? {1'b0, opb} : {(WIDTH+1){1'b0}});
        mul_hi_n = mul_sum[WIDTH:1];
        mul_lo_n = {mul_sum[0], lo[WIDTH-1:1]};

        // Restoring divide: trial subtract, keep it only when non-negative.
        div_shift = {hi, lo[WIDTH-1]};
        div_diff  = div_shift - {1'b0, opb};
        div_hi_n  = div_diff[WIDTH] ? div_shift[WIDTH-1:0] : div_diff[WIDTH-1:0];
        div_lo_n  = {lo[WIDTH-2:0], ~div_diff[WIDTH]};
    end

    // ---------------------------------------------------------------
    // Completion: sign correction and result select
    // ---------------------------------------------------------------
    logic              last, finish;
    logic [2*WIDTH-1:0] prod, prod_s;
    logic [WIDTH-1:0]  mul_res, div_val, div_res, fin_res;

    always_comb begin
        last    = (cnt == CNT_LAST);
        finish  = last || (EARLY_OUT && special_q);

        prod    = {mul_hi_n, mul_lo_n};
        prod_s  = neg_q ? (~prod + 1'b1) : prod;
        mul_res = (funct_q[1:0] == 2'b00) ? prod_s[WIDTH-1:0] : prod_s[2*WIDTH-1:WIDTH];

        div_val = funct_q[1] ? div_hi_n : div_lo_n;
        div_res = neg_q ? (~div_val + 1'b1) : div_val;

        fin_res = special_q ? special_val_q : (funct_q[2] ? div_res : mul_res);
    end

    // ---------------------------------------------------------------
    // FSM
    // ---------------------------------------------------------------
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        o_valid   = (state == DONE);
        o_ready   = (state == IDLE) && i_rst_n;
        case (state)
            IDLE:    if (i_valid) state_nxt = BUSY;
            BUSY:    if (finish)  state_nxt = DONE;
            DONE:    if (i_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        if (i_flush)
            state_nxt = IDLE;
    end

    // ---------------------------------------------------------------
    // Datapath
    // ---------------------------------------------------------------
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            funct_q       <= '0;
            tag_q         <= '0;
            neg_q         <= 1'b0;
            special_q     <= 1'b0;
            special_val_q <= '0;
            cnt           <= '0;
            hi            <= '0;
            lo            <= '0;
            opb           <= '0;
            o_result      <= '0;
            o_tag         <= '0;
        end else if (accept) begin
            funct_q       <= i_funct3;
            tag_q         <= i_tag;
            neg_q         <= req_neg;
            special_q     <= req_special;
            special_val_q <= req_special_val;
            cnt           <= '0;
            hi            <= '0;
            lo            <= req_mul ? b_mag : a_mag;
            opb           <= req_mul ? a_mag : b_mag;
        end else if (state == BUSY && !i_flush) begin
            cnt <= cnt + 1'b1;
            hi  <= funct_q[2] ? div_hi_n : mul_hi_n;
            lo  <= funct_q[2] ? div_lo_n : mul_lo_n;
            if (finish) begin
                o_result <= fin_res;
                o_tag    <= tag_q;
            end
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// tb/tb_muldiv_unit.sv - scoreboard testbench for muldiv_unit (WIDTH=32)

module tb_muldiv_unit;

`ifdef MULDIV_EARLY_OUT_EN
    localparam bit EARLY = 1'b1;
`else
    localparam bit EARLY = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        valid_in;
    logic        ready_out;
    logic [2:0]  funct3;
    logic [31:0] op_a, op_b;
    logic [4:0]  tag_in;
    logic        flush;
    logic        valid_out;
    logic        ready_in;
    logic [31:0] result;
    logic [4:0]  tag_out;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] res;
        logic [4:0]  tag;
    } exp_t;
    exp_t sb_q[$];

    always #5 clk = ~clk;

    muldiv_unit #(.WIDTH(32), .TAG_W(5)) dut (
        .i_clk    (clk),
        .i_rst_n  (rst_n),
        .i_valid  (valid_in),
        .o_ready  (ready_out),
        .i_funct3 (funct3),
        .i_op_a   (op_a),
        .i_op_b   (op_b),
        .i_tag    (tag_in),
        .i_flush  (flush),
        .o_valid  (valid_out),
        .i_ready  (ready_in),
        .o_result (result),
        .o_tag    (tag_out)
    );

    task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", name, obs, exp);
        end
    endtask

    function automatic logic [31:0] model(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] p;
        int sa, sb;
        sa = a;
        sb = b;
        case (f)
            3'd0: begin p = {32'b0, a} * {32'b0, b}; return p[31:0]; end
            3'd1: begin p = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b}); return p[63:32]; end
            3'd2: begin p = $signed({{32{a[31]}}, a}) * $signed({32'b0, b}); return p[63:32]; end
            3'd3: begin p = {32'b0, a} * {32'b0, b}; return p[63:32]; end
            3'd4: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
                return sa / sb;
            end
            3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: begin
                if (b == 0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
                return sa % sb;
            end
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic int lat_for(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        bit special;
        if (f[2])
            special = (b == 0) || (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
        else
            special = (a == 0) || (b == 0);
        return (EARLY && special) ? 1 : 32;
    endfunction

    // Presents a request at a negedge; returns at the negedge after acceptance.
    task automatic start_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                            input logic [4:0] t);
        @(negedge clk);
        chk("ready_idle", ready_out, 1);
        valid_in = 1'b1;
        funct3   = f;
        op_a     = a;
        op_b     = b;
        tag_in   = t;
        @(negedge clk);
        valid_in = 1'b0;
        chk("busy_not_ready", ready_out, 0);
    endtask

    task automatic do_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] t, input logic [31:0] exp_res, input int hold);
        exp_t e;
        int lat;
        e.res = exp_res;
        e.tag = t;
        start_op(f, a, b, t);
        sb_q.push_back(e);
        lat = 0;
        while (!valid_out && lat < 200) begin
            @(negedge clk);
            lat++;
        end
        chk("latency", lat, lat_for(f, a, b));
        if (sb_q.size() > 0) e = sb_q.pop_front();
        chk("result", result, e.res);
        chk("tag", tag_out, e.tag);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk("hold_valid", valid_out, 1);
            chk("hold_result", result, e.res);
            chk("hold_tag", tag_out, e.tag);
            chk("hold_ready", ready_out, 0);
        end
        ready_in = 1'b1;
        // A request offered during the handshake edge must not be taken.
        if (hold > 0) begin
            valid_in = 1'b1;
            funct3   = 3'd0;
            op_a     = 32'd9;
            op_b     = 32'd9;
        end
        @(negedge clk);
        ready_in = 1'b0;
        valid_in = 1'b0;
        chk("handshake_valid", valid_out, 0);
        chk("handshake_ready", ready_out, 1);
    endtask

    initial begin
        bit seen;
        int waited;
        logic [2:0]  rf;
        logic [31:0] ra, rb;

        rst_n    = 1'b0;
        valid_in = 1'b0;
        funct3   = '0;
        op_a     = '0;
        op_b     = '0;
        tag_in   = '0;
        flush    = 1'b0;
        ready_in = 1'b0;
        #1;
        chk("rst_valid", valid_out, 0);
        chk("rst_ready", ready_out, 0);
        chk("rst_result", result, 0);
        chk("rst_tag", tag_out, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Directed values
        do_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd1, 32'hFFFF_FFFE, 0);
        do_op(3'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2, 32'h0000_0001, 0);
        do_op(3'd1, 32'hFFFF_FFFE, 32'h0000_0003, 5'd3, 32'hFFFF_FFFF, 0);
        do_op(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd4, 32'hFFFF_FFFF, 0);
        do_op(3'd4, 32'hFFFF_FFF9, 32'h0000_0002, 5'd5, 32'hFFFF_FFFD, 0);
        do_op(3'd6, 32'hFFFF_FFF9, 32'h0000_0002, 5'd6, 32'hFFFF_FFFF, 0);
        do_op(3'd4, 32'd5, 32'd0, 5'd7, 32'hFFFF_FFFF, 0);
        do_op(3'd6, 32'd5, 32'd0, 5'd8, 32'h0000_0005, 0);
        do_op(3'd5, 32'd5, 32'd0, 5'd9, 32'hFFFF_FFFF, 0);
        do_op(3'd7, 32'hFFFF_FFF9, 32'd0, 5'd10, 32'hFFFF_FFF9, 0);
        do_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd11, 32'h8000_0000, 0);
        do_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd12, 32'h0000_0000, 0);
        do_op(3'd1, 32'd0, 32'h1234_5678, 5'd13, 32'h0000_0000, 0);
        do_op(3'd7, 32'd100, 32'd7, 5'd14, 32'd2, 0);

        // Flush on BUSY cycle 10
        start_op(3'd5, 32'd1000, 32'd3, 5'd20);
        repeat (9) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        chk("flush_busy_valid", valid_out, 0);
        chk("flush_busy_ready", ready_out, 1);
        seen = 1'b0;
        repeat (40) begin
            @(negedge clk);
            seen |= valid_out;
        end
        chk("flush_busy_no_valid", seen, 0);
        do_op(3'd5, 32'd100, 32'd7, 5'd21, 32'd14, 0);

        // Flush in DONE wins over a simultaneous i_ready
        start_op(3'd0, 32'd3, 32'd4, 5'd22);
        waited = 0;
        while (!valid_out && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        chk("flush_done_reached", valid_out, 1);
        flush    = 1'b1;
        ready_in = 1'b1;
        @(negedge clk);
        flush    = 1'b0;
        ready_in = 1'b0;
        chk("flush_done_valid", valid_out, 0);
        chk("flush_done_ready", ready_out, 1);

        // Consumer stalls 5 cycles in DONE
        do_op(3'd3, 32'h1234_5678, 32'h9ABC_DEF0, 5'd23, model(3'd3, 32'h1234_5678, 32'h9ABC_DEF0), 5);

        // Reset mid-BUSY
        start_op(3'd4, 32'd12345, 32'd17, 5'd24);
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midrst_valid", valid_out, 0);
        chk("midrst_ready", ready_out, 0);
        chk("midrst_result", result, 0);
        chk("midrst_tag", tag_out, 0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("postrst_ready", ready_out, 1);
        seen = 1'b0;
        repeat (40) begin
            @(negedge clk);
            seen |= valid_out;
        end
        chk("postrst_no_valid", seen, 0);

        // Random operands against the arithmetic model
        for (int i = 0; i < 8; i++) begin
            rf = 3'($urandom_range(0, 7));
            ra = $urandom;
            rb = $urandom;
            if (i == 7) rb = 32'd0;
            do_op(rf, ra, rb, 5'(i), model(rf, ra, rb), 0);
        end

        chk("scoreboard_empty", sb_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
